// File: rtl/dmem_arb_pkg.sv
// dmem_arb_pkg: shared definitions for the data-memory arbiter.
//   state_t    - sequencer states (IDLE, BEAT, RESP)
//   BEATS      - byte beats per 32-bit word access
//   BEAT_W     - width of the beat counter
//   beat_byte  - big-endian byte selection: beat 0 -> bits 31:24, beat 3 -> bits 7:0
// Optional feature macro used by the top: DMEM_ARB_ALIGN_CHECK_EN.
package dmem_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BEAT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam int BEATS  = 4;
    localparam int BEAT_W = $clog2(BEATS);

    function automatic logic [7:0] beat_byte(input logic [31:0]       word,
                                             input logic [BEAT_W-1:0] beat);
        return word[8*(BEATS-1-int'(beat)) +: 8];
    endfunction

endpackage

// File: rtl/dmem_arbiter_rr_arb2.sv
// rr_arb2: two-request round-robin arbiter.
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset
//   i_req[1:0]  - request lines of port 0 / port 1
//   i_capture   - a grant is being consumed this cycle; updates last-grant
//   o_gnt       - granted port index (only meaningful while any i_req is high)
// The last-grant register resets to port 1 so that port 0 wins the first tie.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] i_req,
    input  logic       i_capture,
    output logic       o_gnt
);

    logic r_last;

    // On a tie hand the grant to the port not served last time; otherwise
    // the single requester wins.
    always_comb begin
        o_gnt = (&i_req) ? ~r_last : i_req[1];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last <= 1'b1;
        end else if (i_capture) begin
            r_last <= o_gnt;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-port arbiter and big-endian byte sequencer for a byte-wide
// data memory of 2^ADDR_W bytes. Each 32-bit word access is carried out as
// four byte beats (MSB byte first) on the memory port.
// Ports:
//   clk, rst_n                  - clock, asynchronous active-low reset
//   i_req0/1, i_we0/1           - request level and write flag per port
//   i_addr0/1, i_wdata0/1       - word byte address (MSB byte) and write word
//   o_ack0/1                    - one-cycle pulse when the request is captured
//   o_rvalid0/1                 - one-cycle pulse when the access completes
//   o_rdata, o_err              - read word / misalignment flag, valid with rvalid
//   o_busy                      - sequencer not idle
//   o_mem_addr/we/wdata         - byte memory port outputs
//   i_mem_rdata                 - byte read data, combinational from o_mem_addr
//   o_dbg_state                 - current sequencer state
// Handshake: a port holds req high until the edge that captures it; ack
// follows in the next cycle and req must drop no later than the cycle after
// ack unless a new request is intended. req is only looked at in IDLE/RESP.
// Macro DMEM_ARB_ALIGN_CHECK_EN: when defined, requests with addr[1:0] != 0
// are acked, skip all beats and complete with err = 1, rdata = 0.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_req0,
    input  logic              i_req1,
    input  logic              i_we0,
    input  logic              i_we1,
    input  logic [ADDR_W-1:0] i_addr0,
    input  logic [ADDR_W-1:0] i_addr1,
    input  logic [31:0]       i_wdata0,
    input  logic [31:0]       i_wdata1,
    output logic              o_ack0,
    output logic              o_ack1,
    output logic              o_rvalid0,
    output logic              o_rvalid1,
    output logic [31:0]       o_rdata,
    output logic              o_err,
    output logic              o_busy,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic              o_mem_we,
    output logic [7:0]        o_mem_wdata,
    input  logic [7:0]        i_mem_rdata,
    output logic [1:0]        o_dbg_state
);

    state_t              r_state;
    state_t              w_next;
    logic [BEAT_W-1:0]   r_beat;
    logic                r_port;
    logic                r_we;
    logic [ADDR_W-1:0]   r_addr;
    logic [31:0]         r_wdata;
    logic [31:0]         r_rdata;
    logic                r_ack0;
    logic                r_ack1;

    logic                w_gnt;
    logic                w_capture;
    logic                w_sel_we;
    logic [ADDR_W-1:0]   w_sel_addr;
    logic [31:0]         w_sel_wdata;
    logic                w_skip;
    logic                w_beat_active;

    // A new word can be taken whenever the sequencer is idle or finishing.
    assign w_capture   = ((r_state == ST_IDLE) || (r_state == ST_RESP)) &&
                         (i_req0 || i_req1);
    assign w_sel_we    = w_gnt ? i_we1    : i_we0;
    assign w_sel_addr  = w_gnt ? i_addr1  : i_addr0;
    assign w_sel_wdata = w_gnt ? i_wdata1 : i_wdata0;

    rr_arb2 u_arb (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_req     ({i_req1, i_req0}),
        .i_capture (w_capture),
        .o_gnt     (w_gnt)
    );

`ifdef DMEM_ARB_ALIGN_CHECK_EN
    logic r_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err <= 1'b0;
        end else if (w_capture) begin
            r_err <= (w_sel_addr[1:0] != 2'b00);
        end
    end

    // A rejected request passes through BEAT for a single cycle with the
    // memory port held quiet, giving rvalid one cycle after ack.
    assign w_skip = r_err;
    assign o_err  = r_err && (r_state == ST_RESP);
`else
    assign w_skip = 1'b0;
    assign o_err  = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE, ST_RESP: w_next = w_capture ? ST_BEAT : ST_IDLE;
            ST_BEAT: begin
                if (w_skip || (r_beat == BEAT_W'(BEATS-1))) begin
                    w_next = ST_RESP;
                end
            end
            default:          w_next = ST_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        w_beat_active = (r_state == ST_BEAT) && !w_skip;
        o_mem_addr    = '0;
        o_mem_we      = 1'b0;
        o_mem_wdata   = 8'h00;
        if (w_beat_active) begin
            // Adding the beat index wraps at the top of memory.
            o_mem_addr = r_addr + {{(ADDR_W-BEAT_W){1'b0}}, r_beat};
            o_mem_we   = r_we;
            if (r_we) begin
                o_mem_wdata = beat_byte(r_wdata, r_beat);
            end
        end
        o_rvalid0   = (r_state == ST_RESP) && !r_port;
        o_rvalid1   = (r_state == ST_RESP) &&  r_port;
        o_busy      = (r_state != ST_IDLE);
        o_dbg_state = r_state;
    end

    // Request capture and byte assembly
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_beat  <= '0;
            r_port  <= 1'b0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
            r_ack0  <= 1'b0;
            r_ack1  <= 1'b0;
        end else begin
            r_ack0 <= w_capture && !w_gnt;
            r_ack1 <= w_capture &&  w_gnt;
            if (w_capture) begin
                r_port  <= w_gnt;
                r_we    <= w_sel_we;
                r_addr  <= w_sel_addr;
                r_wdata <= w_sel_wdata;
                r_beat  <= '0;
                // Cleared here so writes and rejected requests report 0.
                r_rdata <= '0;
            end else if (w_beat_active) begin
                r_beat <= r_beat + BEAT_W'(1);
                if (!r_we) begin
                    r_rdata[8*(BEATS-1-int'(r_beat)) +: 8] <= i_mem_rdata;
                end
            end
        end
    end

    assign o_ack0  = r_ack0;
    assign o_ack1  = r_ack1;
    assign o_rdata = r_rdata;

endmodule
